// File: rtl/vga_pkg.sv
// Shared VGA timing constants, test-pattern codes and colour helpers.
package vga_pkg;

  localparam int unsigned VGA_TOTAL_COLS  = 800;
  localparam int unsigned VGA_TOTAL_ROWS  = 525;
  localparam int unsigned VGA_ACTIVE_COLS = 640;
  localparam int unsigned VGA_ACTIVE_ROWS = 480;

  localparam int unsigned PAT_W = 3;

  localparam logic [PAT_W-1:0] PAT_BLACK    = 3'd0;
  localparam logic [PAT_W-1:0] PAT_RED      = 3'd1;
  localparam logic [PAT_W-1:0] PAT_GREEN    = 3'd2;
  localparam logic [PAT_W-1:0] PAT_BLUE     = 3'd3;
  localparam logic [PAT_W-1:0] PAT_CHECKER  = 3'd4;
  localparam logic [PAT_W-1:0] PAT_BARS     = 3'd5;
  localparam logic [PAT_W-1:0] PAT_BORDER   = 3'd6;
  localparam logic [PAT_W-1:0] PAT_GRADIENT = 3'd7;

  // Widest channel the expand helper supports; callers truncate to their own width.
  localparam int unsigned MAX_VIDEO_WIDTH = 16;

  function automatic logic [MAX_VIDEO_WIDTH-1:0] expand_bit(input logic b);
    return {MAX_VIDEO_WIDTH{b}};
  endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Stage 1: vsync rise detect, col/row recovery and lock flag, with syncs registered alongside.
module vga_pos_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS = VGA_TOTAL_ROWS,
  parameter int unsigned COL_W      = $clog2(TOTAL_COLS),
  parameter int unsigned ROW_W      = $clog2(TOTAL_ROWS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic             frame_start_c,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             locked_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             frame_start_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             locked_q, locked_d;
  logic             hsync_q;
  logic             vsync_q;
  logic             frame_start_q;

  // vsync_q doubles as the previous-vsync sample; it resets high so a rise needs a real low first.
  assign frame_start_c = ~vsync_q & vsync_i;

  always_comb begin
    col_d    = col_q + COL_W'(1);
    row_d    = row_q;
    locked_d = locked_q;
    if (frame_start_c) begin
      col_d    = '0;
      row_d    = '0;
      locked_d = 1'b1;
    end else if (col_q == COL_W'(TOTAL_COLS - 1)) begin
      col_d = '0;
      if (row_q == ROW_W'(TOTAL_ROWS - 1)) begin
        row_d = '0;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q         <= '0;
      row_q         <= '0;
      locked_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      locked_q      <= locked_d;
      hsync_q       <= hsync_i;
      vsync_q       <= vsync_i;
      frame_start_q <= frame_start_c;
    end
  end

  assign col_o         = col_q;
  assign row_o         = row_q;
  assign locked_o      = locked_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_test_pattern_gen.sv
// VGA test-pattern generator: recovers position from raw syncs and emits RGB with 2-clk aligned syncs.
// Define VGA_PATTERN_AUTOCYCLE_EN to step the pattern every AUTO_FRAMES frames instead of using i_pattern.
module vga_test_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = VGA_ACTIVE_ROWS
`ifdef VGA_PATTERN_AUTOCYCLE_EN
  ,
  parameter int unsigned AUTO_FRAMES = 60
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [PAT_W-1:0]       i_pattern,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [VIDEO_WIDTH-1:0] o_red_video,
  output logic [VIDEO_WIDTH-1:0] o_green_video,
  output logic [VIDEO_WIDTH-1:0] o_blue_video,
  output logic                   o_frame_start
);

  localparam int unsigned COL_W = $clog2(TOTAL_COLS);
  localparam int unsigned ROW_W = $clog2(TOTAL_ROWS);
  localparam int unsigned BAR_W = ACTIVE_COLS / 8;
  localparam logic [VIDEO_WIDTH-1:0] FULL = '1;

  logic             frame_start_c;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             locked;
  logic             hsync_s1;
  logic             vsync_s1;
  logic             frame_start_s1;

  vga_pos_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_pos (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .hsync_i       (i_hsync),
    .vsync_i       (i_vsync),
    .frame_start_c (frame_start_c),
    .col_o         (col),
    .row_o         (row),
    .locked_o      (locked),
    .hsync_o       (hsync_s1),
    .vsync_o       (vsync_s1),
    .frame_start_o (frame_start_s1)
  );

  // Pattern is updated on the same edge that zeroes col/row, so a frame never mixes patterns.
  logic [PAT_W-1:0] pattern_q, pattern_d;

`ifdef VGA_PATTERN_AUTOCYCLE_EN
  localparam int unsigned FCNT_W = $clog2(AUTO_FRAMES + 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              unused_pattern;

  assign unused_pattern = ^i_pattern;

  always_comb begin
    pattern_d = pattern_q;
    fcnt_d    = fcnt_q;
    if (frame_start_c) begin
      if (fcnt_q == FCNT_W'(AUTO_FRAMES)) begin
        pattern_d = pattern_q + PAT_W'(1);
        fcnt_d    = FCNT_W'(1);
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pattern_q <= PAT_BLACK;
      fcnt_q    <= '0;
    end else begin
      pattern_q <= pattern_d;
      fcnt_q    <= fcnt_d;
    end
  end
`else
  always_comb begin
    pattern_d = pattern_q;
    if (frame_start_c) begin
      pattern_d = i_pattern;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pattern_q <= PAT_BLACK;
    end else begin
      pattern_q <= pattern_d;
    end
  end
`endif

  logic [VIDEO_WIDTH-1:0] red_d, green_d, blue_d;
  logic [2:0]             bar_idx;
  logic                   in_window;
  logic                   on_border;

  // Stage 2 pixel mux; bar index comes from a comparator chain against multiples of BAR_W.
  always_comb begin
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    bar_idx   = '0;
    for (int unsigned j = 1; j < 8; j++) begin
      if (col >= COL_W'(j * BAR_W)) begin
        bar_idx = 3'(j);
      end
    end
    in_window = locked && (col < COL_W'(ACTIVE_COLS)) && (row < ROW_W'(ACTIVE_ROWS));
    on_border = (col == '0) || (col == COL_W'(ACTIVE_COLS - 1)) ||
                (row == '0) || (row == ROW_W'(ACTIVE_ROWS - 1));
    if (in_window) begin
      case (pattern_q)
        PAT_BLACK: begin
        end
        PAT_RED:   red_d   = FULL;
        PAT_GREEN: green_d = FULL;
        PAT_BLUE:  blue_d  = FULL;
        PAT_CHECKER: begin
          if (col[5] ^ row[5]) begin
            red_d   = FULL;
            green_d = FULL;
            blue_d  = FULL;
          end
        end
        PAT_BARS: begin
          red_d   = VIDEO_WIDTH'(expand_bit(bar_idx[2]));
          green_d = VIDEO_WIDTH'(expand_bit(bar_idx[1]));
          blue_d  = VIDEO_WIDTH'(expand_bit(bar_idx[0]));
        end
        PAT_BORDER: begin
          if (on_border) begin
            red_d   = FULL;
            green_d = FULL;
            blue_d  = FULL;
          end
        end
        PAT_GRADIENT: begin
          red_d   = VIDEO_WIDTH'(col[9:7]);
          green_d = VIDEO_WIDTH'(row[8:6]);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_red_video   <= '0;
      o_green_video <= '0;
      o_blue_video  <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= hsync_s1;
      o_vsync       <= vsync_s1;
      o_red_video   <= red_d;
      o_green_video <= green_d;
      o_blue_video  <= blue_d;
      o_frame_start <= frame_start_s1;
    end
  end

endmodule
